// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared state encoding and default FFT config word for the magnitude frame controller
package fft_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, CONFIG, LOAD, DRAIN, DONE} state_e;
  localparam logic [15:0] CFG_WORD_DEF = 16'h0003;
endpackage

// File: rtl/mag_frame_ctrl.sv
// mag_frame_ctrl: sequences one FFT frame through config, load and magnitude drain,
// throttling the FFT output so at most two beats are in flight toward the squarer.
module mag_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int          FRAME_LEN = 128,
  parameter logic [15:0] CFG_WORD  = CFG_WORD_DEF
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         start,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         err_tlast,
  output logic [$clog2(FRAME_LEN)-1:0] bin_idx,
  output logic [15:0]                  cfg_tdata,
  output logic                         cfg_tvalid,
  input  logic                         cfg_tready,
  input  logic [63:0]                  src_tdata,
  input  logic                         src_tvalid,
  output logic                         src_tready,
  output logic [63:0]                  fft_in_tdata,
  output logic                         fft_in_tvalid,
  input  logic                         fft_in_tready,
  output logic                         fft_in_tlast,
  input  logic                         fft_out_tvalid,
  input  logic                         fft_out_tlast,
  output logic                         fft_out_tready,
  input  logic                         mag_tvalid,
  output logic                         mag_tready,
  input  logic                         sink_tready
);
  localparam int IW = $clog2(FRAME_LEN);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] in_cnt_q, out_cnt_q, fo_cnt_q;
  logic [1:0]    os_q;
  logic          err_q;
  logic          start_acc, cfg_fire, in_fire, fo_fire, mag_fire;

  assign start_acc = (state_q == IDLE) && start;
  assign cfg_fire  = cfg_tvalid && cfg_tready;
  assign in_fire   = fft_in_tvalid && fft_in_tready;
  assign fo_fire   = fft_out_tvalid && fft_out_tready;
  assign mag_fire  = mag_tvalid && mag_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? CONFIG : IDLE;
      CONFIG:  state_d = cfg_fire ? LOAD : CONFIG;
      LOAD:    state_d = (in_fire && in_cnt_q == LAST) ? DRAIN : LOAD;
      DRAIN:   state_d = (mag_fire && out_cnt_q == LAST) ? DONE : DRAIN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q == CONFIG) || (state_q == LOAD) || (state_q == DRAIN);
    frame_done     = state_q == DONE;
    cfg_tvalid     = state_q == CONFIG;
    cfg_tdata      = cfg_tvalid ? CFG_WORD : 16'h0;
    fft_in_tvalid  = (state_q == LOAD) && src_tvalid;
    src_tready     = (state_q == LOAD) && fft_in_tready;
    fft_in_tdata   = (state_q == LOAD) ? src_tdata : 64'h0;
    fft_in_tlast   = (state_q == LOAD) && (in_cnt_q == LAST);
    fft_out_tready = (state_q == DRAIN) && (os_q < 2'd2);
    mag_tready     = (state_q == DRAIN) && sink_tready;
    bin_idx        = out_cnt_q[IW-1:0];
    err_tlast      = err_q;
  end

  // os_q counts FFT beats accepted whose magnitude has not yet been taken downstream
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      fo_cnt_q  <= '0;
      os_q      <= '0;
      err_q     <= 1'b0;
    end else if (start_acc) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      fo_cnt_q  <= '0;
      os_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      if (in_fire)  in_cnt_q  <= in_cnt_q + 1'b1;
      if (mag_fire) out_cnt_q <= out_cnt_q + 1'b1;
      if (fo_fire)  fo_cnt_q  <= fo_cnt_q + 1'b1;
      os_q <= os_q + {1'b0, fo_fire} - {1'b0, mag_fire};
      if (fo_fire && (fft_out_tlast != (fo_cnt_q == LAST))) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mag_frame_ctrl.sv
// tb_mag_frame_ctrl: drives whole frames with the bench standing in for FFT core and squarer chain
module tb_mag_frame_ctrl;
  localparam int N = 8;
  logic        aclk = 1'b0, aresetn = 1'b0, start = 1'b0;
  logic        busy, frame_done, err_tlast;
  logic [2:0]  bin_idx;
  logic [15:0] cfg_tdata;
  logic        cfg_tvalid, cfg_tready = 1'b0;
  logic [63:0] src_tdata = '0, fft_in_tdata;
  logic        src_tvalid = 1'b0, src_tready;
  logic        fft_in_tvalid, fft_in_tready = 1'b0, fft_in_tlast;
  logic        fft_out_tvalid = 1'b0, fft_out_tlast = 1'b0, fft_out_tready;
  logic        mag_tvalid = 1'b0, mag_tready, sink_tready = 1'b0;
  int          n_vec = 0, n_err = 0;
  int          exp_q[$];

  mag_frame_ctrl #(.FRAME_LEN(N)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .busy(busy), .frame_done(frame_done),
    .err_tlast(err_tlast), .bin_idx(bin_idx), .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid),
    .cfg_tready(cfg_tready), .src_tdata(src_tdata), .src_tvalid(src_tvalid), .src_tready(src_tready),
    .fft_in_tdata(fft_in_tdata), .fft_in_tvalid(fft_in_tvalid), .fft_in_tready(fft_in_tready),
    .fft_in_tlast(fft_in_tlast), .fft_out_tvalid(fft_out_tvalid), .fft_out_tlast(fft_out_tlast),
    .fft_out_tready(fft_out_tready), .mag_tvalid(mag_tvalid), .mag_tready(mag_tready),
    .sink_tready(sink_tready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {busy, frame_done, err_tlast, cfg_tvalid, src_tready, fft_in_tvalid,
              fft_in_tlast, fft_out_tready, mag_tready, bin_idx}, '0);
  endtask

  task automatic run_frame(input int cfg_stall, input bit tog, input int bad, input int abort_at, input bit poke);
    int in_n = 0, fo_n = 0, mag_n = 0, pend = 0, cyc = 0;
    bit cfg_done = 0, done = 0, exp_err = 0;
    logic [63:0] d;
    exp_q.delete();
    @(negedge aclk); start = 1'b1;
    @(negedge aclk); start = 1'b0;
    #1 chk("busy_on", busy, 1'b1);
    while (!done && cyc < 300) begin
      if (abort_at >= 0 && in_n == abort_at) begin
        aresetn = 1'b0;
        #1 chk_quiet("abort_quiet");
        @(negedge aclk); aresetn = 1'b1;
        return;
      end
      d = {$urandom, $urandom};
      cfg_tready     = cyc >= cfg_stall;
      src_tdata      = d;
      src_tvalid     = tog ? 1'($urandom_range(0, 1)) : 1'b1;
      fft_in_tready  = tog ? 1'($urandom_range(0, 1)) : 1'b1;
      fft_out_tvalid = fo_n < N;
      fft_out_tlast  = (fo_n == N - 1) != (fo_n == bad);
      mag_tvalid     = pend > 0;
      sink_tready    = tog ? cyc[0] : 1'b1;
      start          = poke && in_n == N && mag_n == 2;
      #1;
      chk("cfg_tvalid", cfg_tvalid, !cfg_done);
      if (cfg_tvalid) chk("cfg_tdata", cfg_tdata, 16'h0003);
      chk("src_tready", src_tready, cfg_done && in_n < N && fft_in_tready);
      chk("fft_in_tvalid", fft_in_tvalid, cfg_done && in_n < N && src_tvalid);
      chk("fft_out_tready", fft_out_tready, in_n == N && mag_n < N && pend < 2);
      chk("mag_tready", mag_tready, in_n == N && mag_n < N && sink_tready);
      chk("err_tlast", err_tlast, exp_err);
      chk("frame_done", frame_done, mag_n == N);
      if (frame_done) begin
        chk("mag_count", mag_n, N);
        done = 1;
        start = 1'b1;
      end
      if (cfg_tvalid && cfg_tready) cfg_done = 1;
      if (fft_in_tvalid && fft_in_tready) begin
        chk("fft_in_tdata", fft_in_tdata, d);
        chk("fft_in_tlast", fft_in_tlast, in_n == N - 1);
        in_n++;
      end
      if (mag_tvalid && mag_tready) begin
        chk("bin_idx", bin_idx, exp_q.pop_front());
        pend--;
        mag_n++;
      end
      if (fft_out_tvalid && fft_out_tready) begin
        if (fft_out_tlast != (fo_n == N - 1)) exp_err = 1;
        exp_q.push_back(fo_n);
        fo_n++;
        pend++;
      end
      @(negedge aclk); cyc++;
    end
    if (!done) chk("timeout", 1'b0, 1'b1);
    start = 1'b0;
    {fft_out_tvalid, mag_tvalid, src_tvalid} = '0;
    #1;
    chk("busy_after", busy, 1'b0);
    chk("done_once", frame_done, 1'b0);
    chk("err_hold", err_tlast, exp_err);
  endtask

  initial begin
    repeat (3) @(negedge aclk);
    #1 chk_quiet("reset_quiet");
    aresetn = 1'b1;
    run_frame(0, 0, -1, -1, 0);
    run_frame(5, 0, -1, -1, 0);
    run_frame(0, 1, -1, -1, 0);
    run_frame(0, 0, 4, -1, 0);
    run_frame(0, 0, -1, -1, 0);
    run_frame(0, 0, -1, 3, 0);
    run_frame(0, 0, -1, -1, 0);
    run_frame(0, 1, -1, -1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mag_frame_ctrl.md
MAG_FRAME_CTRL -- requirements
Module: mag_frame_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 128: samples per FFT frame (power of two, 8..1024).
REQ-002 Parameter CFG_WORD, default 16'h0003: FFT config word (forward transform, scaling) issued once per frame.
REQ-003 Port aclk  in  1  sole clock; all logic rising-edge.
REQ-004 Port aresetn  in  1  asynchronous, active-low reset.
REQ-005 Port start  in  1  one-cycle request to process one frame; ignored unless idle.
REQ-006 Port busy  out  1  high from accepted start until frame_done.
REQ-007 Port frame_done  out  1  one-cycle pulse when last magnitude accepted.
REQ-008 Port err_tlast  out  1  sticky: FFT output tlast misaligned with bin count; cleared by accepted start.
REQ-009 Port bin_idx  out  $clog2(FRAME_LEN)  index of magnitude currently offered downstream.
REQ-010 Ports cfg_tdata out 16 / cfg_tvalid out 1 / cfg_tready in 1: FFT config stream.
REQ-011 Ports src_tdata in 64 / src_tvalid in 1 / src_tready out 1: upstream sample stream (Im[63:32], Re[31:0]).
REQ-012 Ports fft_in_tdata out 64 / fft_in_tvalid out 1 / fft_in_tready in 1 / fft_in_tlast out 1: FFT data input.
REQ-013 Ports fft_out_tvalid in 1 / fft_out_tlast in 1 / fft_out_tready out 1: FFT output handshake, gated toward the squarer.
REQ-014 Ports mag_tvalid in 1 / mag_tready out 1 / sink_tready in 1: adder output handshake and downstream acceptance.

Function
REQ-015 States IDLE, CONFIG, LOAD, DRAIN, DONE; IDLE->CONFIG on start.
REQ-016 CONFIG: cfg_tdata=CFG_WORD, cfg_tvalid=1; advance to LOAD in the cycle after cfg_tvalid&&cfg_tready.
REQ-017 LOAD: fft_in_tdata=src_tdata combinationally; fft_in_tvalid=src_tvalid; src_tready=fft_in_tready; both 0 outside LOAD.
REQ-018 LOAD: in_cnt increments on each fft_in_tvalid&&fft_in_tready; fft_in_tlast=1 only when in_cnt==FRAME_LEN-1; LOAD->DRAIN after that transfer.
REQ-019 DRAIN: fft_out_tready=1 while fewer than 2 fft_out beats are outstanding (accepted but magnitude not yet accepted); else 0.
REQ-020 DRAIN: mag_tready=sink_tready; out_cnt increments on mag_tvalid&&mag_tready; bin_idx=out_cnt.
REQ-021 fft_out_tlast on an accepted fft_out beat whose index != FRAME_LEN-1, or tlast absent on beat FRAME_LEN-1, sets err_tlast; the frame continues.
REQ-022 DRAIN->DONE on magnitude transfer with out_cnt==FRAME_LEN-1; DONE asserts frame_done one cycle, then IDLE.
REQ-023 Counters width $clog2(FRAME_LEN)+1; no wrap within a frame; cleared on entry to CONFIG.
REQ-024 start while busy is ignored; start in DONE cycle is ignored.
REQ-025 Outstanding-beat counter: simultaneous fft_out accept and mag accept leaves it unchanged.
REQ-026 Beats on fft_out/mag outside DRAIN are never accepted (readies 0).

Reset
REQ-027 aresetn low: state IDLE, counters 0, busy/frame_done/err_tlast 0, all tvalid/tready/tlast outputs 0, bin_idx 0.
REQ-028 Reset mid-frame aborts immediately; no frame_done; next start begins with CONFIG.

Structure
REQ-029 State enum and default CFG_WORD belong in shared package fft_ctrl_pkg.
REQ-030 Single module, no sub-modules; the beat counter logic stays inline.

Verification
REQ-031 FRAME_LEN=8, start, cfg_tready=1, src all valid -> cfg_tdata=16'h0003 one beat, 8 input beats, tlast on 8th only, frame_done after 8th magnitude.
REQ-032 cfg_tready held 0 for 5 cycles -> cfg_tvalid stays 1, src_tready 0 throughout, LOAD entered after handshake.
REQ-033 sink_tready toggled 1/0 during DRAIN -> fft_out_tready drops when 2 beats outstanding, exactly 8 magnitudes, bin_idx 0..7 in order.
REQ-034 fft_out_tlast on beat 5 of 8 -> err_tlast=1 sticky, frame_done still pulses; next start clears it.
REQ-035 aresetn low during LOAD beat 3 -> all outputs 0 next edge-independent; new start yields complete correct frame.
REQ-036 start pulsed during DRAIN -> ignored; only one frame_done.
